// File: rtl/par_ser_tx.sv
// par_ser_tx: byte FIFO + MSB-first serializer that trains with 0xBC commas and fills idle slots with 0xBC.
// Optional PAR_SER_RESYNC_EN forces a 0xBC after RESYNC_PERIOD back-to-back data symbols.
module par_ser_tx #(
    parameter int TRAIN_BC      = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int RESYNC_PERIOD = 16
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       sym_start,
    output logic       sym_is_data,
    output logic       active
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0] COMMA = 8'hBC;

    if (TRAIN_BC < 1 || TRAIN_BC > 15) begin : g_bad_train
        $error("TRAIN_BC must be 1..15");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two in 2..16");
    end
    if (RESYNC_PERIOD < 2 || RESYNC_PERIOD > 255) begin : g_bad_resync
        $error("RESYNC_PERIOD must be 2..255");
    end

    typedef enum logic {TRAIN, RUN} state_e;

    state_e          state_q, state_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [3:0]      bc_cnt_q, bc_cnt_d;
    logic            active_q, active_d;
    logic            is_data_q, is_data_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic            load, push, pop, train_done, run_load, force_comma;

`ifdef PAR_SER_RESYNC_EN
    logic [7:0]      run_cnt_q, run_cnt_d;
    assign force_comma = run_cnt_q == 8'(RESYNC_PERIOD);
`else
    assign force_comma = 1'b0;
`endif

    assign load       = bit_cnt_q == 3'd0;
    assign ready_out  = count_q != CW'(FIFO_DEPTH);
    assign push       = valid_in & ready_out;
    assign train_done = bc_cnt_q + 4'd1 == 4'(TRAIN_BC);
    // The TRAIN->RUN load edge already carries the first RUN symbol.
    assign run_load   = load & (state_q == RUN | train_done);
    assign pop        = run_load & (count_q != '0) & ~force_comma;

    assign data_out    = shreg_q[7];
    assign sym_start   = bit_cnt_q == 3'd7;
    assign sym_is_data = is_data_q;
    assign active      = active_q;

    always_comb begin
        state_d   = state_q;
        bc_cnt_d  = bc_cnt_q;
        active_d  = active_q;
        is_data_d = is_data_q;
        shreg_d   = {shreg_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q - 3'd1;
        wr_ptr_d  = wr_ptr_q + AW'(push);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        count_d   = count_q + CW'(push) - CW'(pop);
        if (load) begin
            bit_cnt_d = 3'd7;
            shreg_d   = pop ? mem_q[rd_ptr_q] : COMMA;
            is_data_d = pop;
            if (state_q == TRAIN) begin
                bc_cnt_d = bc_cnt_q + 4'd1;
                if (train_done) begin
                    state_d  = RUN;
                    active_d = 1'b1;
                end
            end
        end
    end

`ifdef PAR_SER_RESYNC_EN
    always_comb begin
        run_cnt_d = run_cnt_q;
        if (run_load) run_cnt_d = pop ? run_cnt_q + 8'd1 : 8'd0;
    end
`endif

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q   <= TRAIN;
            shreg_q   <= COMMA;
            bit_cnt_q <= 3'd7;
            bc_cnt_q  <= 4'd0;
            active_q  <= 1'b0;
            is_data_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
`ifdef PAR_SER_RESYNC_EN
            run_cnt_q <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
            active_q  <= active_d;
            is_data_q <= is_data_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
`ifdef PAR_SER_RESYNC_EN
            run_cnt_q <= run_cnt_d;
`endif
        end
    end

    // Storage needs no reset: count/pointers define which entries are valid.
    always_ff @(posedge clk_32f) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end
endmodule

// File: tb/tb_par_ser_tx.sv
// tb_par_ser_tx: directed vector bench for par_ser_tx; per-cycle line samples are logged and decoded into symbols.
module tb_par_ser_tx;
    logic       clk_32f = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_out, data_out, sym_start, sym_is_data, active;

    par_ser_tx dut (
        .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .data_out(data_out), .sym_start(sym_start),
        .sym_is_data(sym_is_data), .active(active)
    );

    always #5 clk_32f = ~clk_32f;

    typedef struct {
        logic       push;
        int         off;
        logic [7:0] din;
        logic [7:0] esym;
        logic       edata;
        logic       eact;
    } vec_t;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    logic [7:0] txq [$];
    logic       sched_v [1024];
    logic [7:0] sched_d [1024];
    logic       dout_l [1024];
    logic       sst_l [1024];
    logic       isd_l [1024];
    logic       rdy_l [1024];
    logic       act_l [1024];
    vec_t       vt [14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Cycle c = values presented to posedge c (sampled on the preceding negedge).
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            if (sched_v[cyc]) txq.push_back(sched_d[cyc]);
            valid_in = txq.size() > 0;
            data_in  = valid_in ? txq[0] : 8'h00;
            dout_l[cyc] = data_out;
            sst_l[cyc]  = sym_start;
            isd_l[cyc]  = sym_is_data;
            rdy_l[cyc]  = ready_out;
            act_l[cyc]  = active;
            if (valid_in && ready_out) void'(txq.pop_front());
            cyc++;
            @(negedge clk_32f);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        valid_in = 1'b0;
        data_in = 8'h00;
        txq.delete();
        for (int i = 0; i < 1024; i++) sched_v[i] = 1'b0;
        @(negedge clk_32f);
        @(negedge clk_32f);
        reset = 1'b1;
        cyc = 0;
    endtask

    function automatic logic [7:0] sym_at(input int k);
        logic [7:0] s = 8'h00;
        for (int j = 0; j < 8; j++) s = {s[6:0], dout_l[8*k+j]};
        return s;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " data_out"}, data_out, 1'b1);
        check({tag, " sym_start"}, sym_start, 1'b1);
        check({tag, " sym_is_data"}, sym_is_data, 1'b0);
        check({tag, " active"}, active, 1'b0);
        check({tag, " ready_out"}, ready_out, 1'b1);
    endtask

    initial begin
        int b;
        logic [7:0] es;
        logic       ed;
        for (int i = 0; i < 1024; i++) sched_v[i] = 1'b0;
        @(negedge clk_32f);
        @(negedge clk_32f);
        check_reset_outputs("por");

        // Training, push during training, idle fill, push timing around load edges, data byte 0xBC.
        vt[0]  = '{1'b1, 2, 8'hA5, 8'hBC, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 0, 8'h00, 8'hBC, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 0, 8'h00, 8'hBC, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 0, 8'h00, 8'hBC, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 0, 8'h00, 8'hA5, 1'b1, 1'b1};
        vt[5]  = '{1'b1, 6, 8'h3C, 8'hBC, 1'b0, 1'b1};
        vt[6]  = '{1'b1, 7, 8'h5A, 8'h3C, 1'b1, 1'b1};
        vt[7]  = '{1'b0, 0, 8'h00, 8'hBC, 1'b0, 1'b1};
        vt[8]  = '{1'b1, 0, 8'hBC, 8'h5A, 1'b1, 1'b1};
        vt[9]  = '{1'b0, 0, 8'h00, 8'hBC, 1'b1, 1'b1};
        vt[10] = '{1'b1, 7, 8'h81, 8'hBC, 1'b0, 1'b1};
        vt[11] = '{1'b0, 0, 8'h00, 8'hBC, 1'b0, 1'b1};
        vt[12] = '{1'b0, 0, 8'h00, 8'h81, 1'b1, 1'b1};
        vt[13] = '{1'b0, 0, 8'h00, 8'hBC, 1'b0, 1'b1};
        for (int k = 0; k < 14; k++) begin
            sched_v[8*k+vt[k].off] = vt[k].push;
            sched_d[8*k+vt[k].off] = vt[k].din;
        end
        reset = 1'b1;
        cyc = 0;
        run(8 * 14);
        for (int k = 0; k < 14; k++) begin
            check($sformatf("v%0d symbol", k), sym_at(k), vt[k].esym);
            check($sformatf("v%0d active", k), act_l[8*k], vt[k].eact);
            for (int j = 0; j < 8; j++) begin
                check($sformatf("v%0d bit%0d sym_is_data", k, j), isd_l[8*k+j], vt[k].edata);
                check($sformatf("v%0d bit%0d sym_start", k, j), sst_l[8*k+j], j == 0);
            end
        end

        // Continuous stream 1..20 with valid held: backpressure, ordering, optional resync comma.
        do_reset();
        for (int i = 1; i <= 20; i++) txq.push_back(8'(i));
        run(8 * 26);
        check("stream ready c3", rdy_l[3], 1'b1);
        check("stream ready c4", rdy_l[4], 1'b0);
        check("stream ready c31", rdy_l[31], 1'b0);
        check("stream ready c32", rdy_l[32], 1'b1);
        check("stream ready c33", rdy_l[33], 1'b0);
        check("stream active c24", act_l[24], 1'b0);
        check("stream all bytes taken", txq.size(), 0);
        b = 1;
        for (int k = 4; k < 26; k++) begin
`ifdef PAR_SER_RESYNC_EN
            if (k == 20) begin
                es = 8'hBC;
                ed = 1'b0;
            end else
`endif
            if (b <= 20) begin
                es = 8'(b);
                ed = 1'b1;
                b++;
            end else begin
                es = 8'hBC;
                ed = 1'b0;
            end
            check($sformatf("stream sym%0d", k), sym_at(k), es);
            check($sformatf("stream sym%0d is_data", k), isd_l[8*k], ed);
        end

        // Reset at bit 3 of a data byte with a full FIFO behind it.
        do_reset();
        txq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run(36);
        check("mid data_out bit3", data_out, 1'b0);
        check("mid sym_is_data", sym_is_data, 1'b1);
        check("mid active", active, 1'b1);
        check("mid ready_out full", ready_out, 1'b0);
        #2 reset = 1'b0;
        #1 check_reset_outputs("async");
        txq.delete();
        valid_in = 1'b0;
        @(negedge clk_32f);
        reset = 1'b1;
        cyc = 0;
        run(8 * 6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("retrain sym%0d", k), sym_at(k), 8'hBC);
            check($sformatf("retrain sym%0d is_data", k), isd_l[8*k], 1'b0);
        end
        check("retrain active c24", act_l[24], 1'b0);
        check("retrain active c40", act_l[40], 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
